// File: rtl/pe_l2_l1_refill_sched_if.sv
// L2/L1 refill scheduler bus: requester handshake plus L2 and L1 port controls.
// Master is the scheduler; slave is the requester/memory side.
interface pe_l2_l1_refill_sched_if #(
  parameter int L2_AW = 11,
  parameter int L1_AW = 5
);
  logic [2:0]         req;
  logic [3*L2_AW-1:0] base_addr;
  logic [2:0]         gnt;
  logic [2:0]         done;
  logic               l2_vld;
  logic               l2_rdy;
  logic               l2_we;
  logic [L2_AW-1:0]   l2_addr;
  logic [1:0]         l1_sel;
  logic               l1_we;
  logic               l1_re;
  logic [L1_AW-1:0]   l1_addr;

  modport master (
    input  req, base_addr, l2_rdy,
    output gnt, done, l2_vld, l2_we, l2_addr,
    output l1_sel, l1_we, l1_re, l1_addr
  );

  modport slave (
    output req, base_addr, l2_rdy,
    input  gnt, done, l2_vld, l2_we, l2_addr,
    input  l1_sel, l1_we, l1_re, l1_addr
  );
endinterface

// File: rtl/pe_l2_l1_refill_sched.sv
// Shares one L2 SRAM port among I refill, W refill and O writeback in bursts.
// Define SCHED_O_PRIO_EN to give O writeback strict priority over I/W.
module pe_l2_l1_refill_sched #(
  parameter int L2_AW = 11,
  parameter int L1_AW = 5,
  parameter int BURST = 32
) (
  input logic clk,
  input logic rst,
  pe_l2_l1_refill_sched_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [L1_AW-1:0] LAST_BEAT = L1_AW'(BURST - 1);

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       win_q, win_d;
  logic [L1_AW-1:0] beat_q, beat_d;
  logic [L2_AW-1:0] base_q, base_d;
  logic [1:0]       pick;
  logic             any_req;
  logic             hs;

  assign any_req = |bus.req;
  assign hs      = (state_q == XFER) && bus.l2_rdy;

  // Round-robin search starting at rr_ptr, order 0,1,2 with wrap
  always_comb begin
    pick = 2'd0;
    unique case (rr_ptr_q)
      2'd1:    pick = bus.req[1] ? 2'd1 :
                      bus.req[2] ? 2'd2 : 2'd0;
      2'd2:    pick = bus.req[2] ? 2'd2 :
                      bus.req[0] ? 2'd0 : 2'd1;
      default: pick = bus.req[0] ? 2'd0 :
                      bus.req[1] ? 2'd1 : 2'd2;
    endcase
`ifdef SCHED_O_PRIO_EN
    if (bus.req[2]) pick = 2'd2;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      win_q    <= '0;
      beat_q   <= '0;
      base_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = XFER;
      XFER:    if (hs && beat_q == LAST_BEAT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    beat_d   = beat_q;
    base_d   = base_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d  = pick;
          base_d = bus.base_addr[pick*L2_AW +: L2_AW];
          beat_d = '0;
        end
      end
      XFER: begin
        if (hs) beat_d = beat_q + 1'b1;
      end
      DONE: begin
`ifdef SCHED_O_PRIO_EN
        // O grants leave the I/W rotation untouched
        if (win_q != 2'd2)
          rr_ptr_d = (win_q == 2'd1) ? 2'd2 : 2'd1;
`else
        rr_ptr_d = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.gnt     = '0;
    bus.done    = '0;
    bus.l2_vld  = 1'b0;
    bus.l2_we   = 1'b0;
    bus.l2_addr = '0;
    bus.l1_sel  = '0;
    bus.l1_we   = 1'b0;
    bus.l1_re   = 1'b0;
    bus.l1_addr = '0;
    unique case (state_q)
      XFER: begin
        bus.gnt     = 3'b001 << win_q;
        bus.l2_vld  = 1'b1;
        bus.l2_we   = (win_q == 2'd2);
        bus.l2_addr = base_q + L2_AW'(beat_q);
        bus.l1_sel  = win_q;
        bus.l1_we   = bus.l2_rdy && (win_q != 2'd2);
        bus.l1_re   = (win_q == 2'd2);
        bus.l1_addr = beat_q;
      end
      DONE:    bus.done = 3'b001 << win_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_l2_l1_refill_sched.sv
// Directed bench for pe_l2_l1_refill_sched: bursts, arbitration, stalls,
// address wrap and mid-burst reset.
module tb_pe_l2_l1_refill_sched;

  localparam int L2_AW = 11;
  localparam int L1_AW = 5;
  localparam int BURST = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_l2_l1_refill_sched_if #(.L2_AW(L2_AW), .L1_AW(L1_AW)) bus ();

  pe_l2_l1_refill_sched #(
    .L2_AW(L2_AW), .L1_AW(L1_AW), .BURST(BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_base(input logic [10:0] b0, input logic [10:0] b1,
                          input logic [10:0] b2);
    bus.base_addr = {b2, b1, b0};
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_gnt"},  bus.gnt, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_vld"},  bus.l2_vld, 0);
    chk({tag, "_l2we"}, bus.l2_we, 0);
    chk({tag, "_l2a"},  bus.l2_addr, 0);
    chk({tag, "_sel"},  bus.l1_sel, 0);
    chk({tag, "_l1we"}, bus.l1_we, 0);
    chk({tag, "_l1re"}, bus.l1_re, 0);
    chk({tag, "_l1a"},  bus.l1_addr, 0);
  endtask

  // Entered at the negedge where the grant must first be visible
  task automatic run_burst(input string tag, input int w,
                           input logic [10:0] base, input bit stall);
    int beat, bad, cyc, we_cnt;
    logic rdy;
    logic [10:0] ea;
    beat = 0; bad = 0; cyc = 0; we_cnt = 0;
    chk({tag, "_gnt"}, bus.gnt, 32'(1 << w));
    while (cyc < 200) begin
      if (bus.done !== 3'b000) break;
      rdy = stall ? cyc[0] : 1'b1;
      bus.l2_rdy = rdy;
      #1;
      ea = base + 11'(beat);
      if (!bus.l2_vld || bus.gnt !== 3'(1 << w) ||
          bus.l2_addr !== ea || bus.l1_addr !== 5'(beat) ||
          bus.l1_sel !== 2'(w) || bus.l2_we !== (w == 2) ||
          bus.l1_re !== (w == 2) ||
          bus.l1_we !== (rdy && w != 2))
        bad++;
      if (rdy) begin
        beat++;
        if (bus.l1_we) we_cnt++;
      end
      cyc++;
      @(negedge clk);
    end
    bus.l2_rdy = 1'b1;
    chk({tag, "_done"},  bus.done, 32'(1 << w));
    chk({tag, "_dgnt"},  bus.gnt, 0);
    chk({tag, "_dvld"},  bus.l2_vld, 0);
    chk({tag, "_beats"}, beat, BURST);
    chk({tag, "_cyc"},   cyc, stall ? 2 * BURST : BURST);
    chk({tag, "_bad"},   bad, 0);
    chk({tag, "_l1we"},  we_cnt, (w == 2) ? 0 : BURST);
  endtask

  int ord[4];
  logic [10:0] bs[3];
  int w6;

  initial begin
    bus.req = '0;
    bus.l2_rdy = 1'b1;
    set_base(11'h0, 11'h0, 11'h0);
    repeat (2) @(negedge clk);
    quiet("rst");
    rst = 1'b1;

    // single I burst
    set_base(11'h100, 11'h0, 11'h0);
    bus.req = 3'b001;
    @(negedge clk);
    run_burst("t1", 0, 11'h100, 1'b0);
    bus.req = '0;
    @(negedge clk);
    chk("t1_idle_gnt", bus.gnt, 0);
    @(negedge clk);
    chk("t1_idle2_vld", bus.l2_vld, 0);

    // all three requesting after reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bs[0] = 11'h010; bs[1] = 11'h200; bs[2] = 11'h400;
    set_base(bs[0], bs[1], bs[2]);
`ifdef SCHED_O_PRIO_EN
    ord = '{2, 2, 2, 2};
`else
    ord = '{0, 1, 2, 0};
`endif
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      run_burst($sformatf("t2_%0d", k), ord[k], bs[ord[k]], 1'b0);
      if (k == 3) bus.req = '0;
      @(negedge clk);
      chk($sformatf("t2_gap%0d", k), bus.gnt, 0);
    end
    @(negedge clk);

    // W burst with l2_rdy toggling
    set_base(11'h0, 11'h055, 11'h0);
    bus.req = 3'b010;
    @(negedge clk);
    run_burst("t3", 1, 11'h055, 1'b1);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // O writeback wrapping the L2 address space
    set_base(11'h0, 11'h0, 11'h7F0);
    bus.req = 3'b100;
    @(negedge clk);
    run_burst("t4", 2, 11'h7F0, 1'b0);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // reset at beat 10 of an I burst, then restart
    set_base(11'h300, 11'h0, 11'h0);
    bus.req = 3'b001;
    @(negedge clk);
    chk("t5_gnt", bus.gnt, 3'b001);
    repeat (10) @(negedge clk);
    chk("t5_b10_l2a", bus.l2_addr, 11'h30A);
    chk("t5_b10_l1a", bus.l1_addr, 10);
    rst = 1'b0;
    @(negedge clk);
    quiet("t5");
    rst = 1'b1;
    @(negedge clk);
    run_burst("t5r", 0, 11'h300, 1'b0);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // req=101 from rr_ptr=0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_base(11'h020, 11'h0, 11'h600);
    bus.req = 3'b101;
`ifdef SCHED_O_PRIO_EN
    w6 = 2;
`else
    w6 = 0;
`endif
    @(negedge clk);
    run_burst("t6", w6, (w6 == 2) ? 11'h600 : 11'h020, 1'b0);
    bus.req = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
